idu_pc_gen: RTL and testbench
=============================

Name: idu_pc_gen

Overview:
- Parametrised successor of the IDU fetch-PC register with its single-entry branch-target holding register.
- Generalises to XLEN-wide PCs and a BJU_DEPTH-entry FIFO retention station for resolved branch/jump targets.
- Adds flush redirect, a held-pending ROB jump across stalls, occupancy/status outputs and error flags.
- Sits in IDU register-fetch stage: EXU BJU pushes resolved targets, ROB commit pops them into pc.

Parameters:
XLEN, 64, PC and target width in bits
PC_RESET, 64'h0000_0000_8000_0000, pc value after reset (truncated to XLEN)
BJU_DEPTH, 4, retention-station entries; power of two, 2..16
INST_BYTES, 4, sequential pc increment; 2 or 4

Ports:
clk  in  1  clock
rst_clk  in  1  synchronous active-high reset
y_stall_ctrl  in  1  pipeline stall; hold pc
exu_idu_rf_bju_pcjump_vld  in  1  BJU resolved-target push request
exu_idu_rf_bju_pcjump_addr  in  XLEN  pushed target address
idu_exu_rf_bju_pcjump_rdy  out  1  station can accept push (= !full)
rob_idu_rf_pcjump_vld  in  1  ROB commits taken branch; redirect pc to oldest target
rob_idu_rf_flush_vld  in  1  ROB flush/exception redirect
rob_idu_rf_flush_addr  in  XLEN  flush target
pc  out  XLEN  current fetch pc
bju_rs_cnt  out  $clog2(BJU_DEPTH)+1  valid entries
bju_rs_empty  out  1  cnt==0
bju_rs_full  out  1  cnt==BJU_DEPTH
bju_rs_ovf  out  1  sticky: push attempted while full with no pop
bju_rs_unf  out  1  sticky: redirect needed a target but none available

Behaviour:
- Reset (sync, rst_clk=1 at posedge): pc=PC_RESET, wr/rd pointers=0, cnt=0, jump_pend=0, ovf=0, unf=0. Reset overrides all inputs; mid-operation reset discards all entries.
- Priority on pc each cycle: flush > stall > redirect > sequential.
- Flush: pc <= flush_addr with low log2(INST_BYTES) bits cleared; station emptied (pointers, cnt=0); jump_pend cleared; any same-cycle push and pop discarded. Flush acts even when y_stall_ctrl=1. Sticky flags are not cleared.
- Stall (no flush): pc holds. rob_pcjump_vld during stall sets jump_pend=1; no pop. Pushes still accepted during stall.
- Redirect request = rob_pcjump_vld | jump_pend, when not stalled and not flushing:
  - Station non-empty: pc <= head entry; pop; jump_pend <= 0.
  - Station empty: see optional feature.
- Sequential: pc <= pc + INST_BYTES, modulo 2^XLEN (all-ones wraps to low values).
- Push: accepted when vld && (!full || pop this cycle). Full with simultaneous pop: push accepted, cnt unchanged, pointers both advance. Full without pop: push dropped, ovf <= 1.
- Pointers wrap modulo BJU_DEPTH; cnt = pushes − pops, never exceeds BJU_DEPTH.
- rdy, empty, full, cnt derived from registered state only (no combinational path from inputs).
- Latency: push visible at head next cycle; redirect updates pc next cycle.

Optional Feature:
IDU_PC_GEN_BJU_BYPASS_EN
- Defined: redirect with empty station and same-cycle push takes pc <= exu_idu_rf_bju_pcjump_addr directly; entry is not stored (cnt stays 0); jump_pend cleared. Empty station, no push: jump_pend <= 1, pc holds, unf not set; resolved on the next push.
- Not defined: any redirect with empty station sets unf <= 1, clears jump_pend, pc <= pc + INST_BYTES; a same-cycle push is enqueued normally.

Test Plan:
- Reset: assert rst_clk 2 cycles -> pc=0x80000000, cnt=0, empty=1, rdy=1, ovf=unf=0; release -> pc 0x80000004, 0x80000008 on successive cycles.
- Push 0x1000, 0x2000, 0x3000, 0x4000 -> full=1, rdy=0; 5th push 0x5000 -> dropped, ovf=1; rob jump x2 -> pc 0x1000 then 0x2000, cnt=2.
- Full station + simultaneous push 0x6000 and rob jump -> pc=head, cnt stays 4, 0x6000 is tail, ovf unchanged.
- Stall=1 with rob jump pulse at head 0xA000 -> pc holds for whole stall; first unstalled cycle pc=0xA000, cnt decremented once.
- Two entries queued, flush_vld with addr 0x9003 while stalled plus push -> pc=0x9000, cnt=0, push discarded, jump_pend=0.
- Empty station rob jump with push 0xB000: macro defined -> pc=0xB000, cnt=0; undefined -> pc=pc+4, unf=1, cnt=1; also pc=0xFFFF_FFFF_FFFF_FFFC sequential -> 0x0.

Source files
------------

// File: rtl/idu_pc_gen.sv
// idu_pc_gen: IDU register-fetch PC generator.
// Holds the fetch pc and a BJU_DEPTH-entry FIFO retention station of resolved
// branch/jump targets. EXU BJU pushes targets; ROB commit pops them into pc.
// pc priority each cycle: flush > stall > redirect > sequential.
// Optional feature macro: IDU_PC_GEN_BJU_BYPASS_EN
//   defined   - a redirect that finds the station empty takes a same-cycle
//               push straight into pc, or waits (jump pending) for one.
//   undefined - a redirect that finds the station empty flags underflow and
//               falls through to the sequential pc.
module idu_pc_gen #(
  parameter int          XLEN       = 64,
  parameter logic [63:0] PC_RESET   = 64'h0000_0000_8000_0000,
  parameter int          BJU_DEPTH  = 4,
  parameter int          INST_BYTES = 4
) (
  input  logic                         clk,
  input  logic                         rst_clk,
  input  logic                         y_stall_ctrl,
  input  logic                         exu_idu_rf_bju_pcjump_vld,
  input  logic [XLEN-1:0]              exu_idu_rf_bju_pcjump_addr,
  output logic                         idu_exu_rf_bju_pcjump_rdy,
  input  logic                         rob_idu_rf_pcjump_vld,
  input  logic                         rob_idu_rf_flush_vld,
  input  logic [XLEN-1:0]              rob_idu_rf_flush_addr,
  output logic [XLEN-1:0]              pc,
  output logic [$clog2(BJU_DEPTH):0]   bju_rs_cnt,
  output logic                         bju_rs_empty,
  output logic                         bju_rs_full,
  output logic                         bju_rs_ovf,
  output logic                         bju_rs_unf
);

  localparam int PTR_W = $clog2(BJU_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [XLEN-1:0]  PC_RST_VAL = XLEN'(PC_RESET);
  localparam logic [XLEN-1:0]  PC_INC     = XLEN'(INST_BYTES);
  // Clears the low log2(INST_BYTES) bits of a flush target.
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(BJU_DEPTH);

  // Registered state
  logic [XLEN-1:0]  pc_q,        pc_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             jump_pend_q, jump_pend_d;
  logic             ovf_q,       ovf_d;
  logic             unf_q,       unf_d;
  logic [XLEN-1:0]  mem_q [BJU_DEPTH];

  // Per-cycle decisions
  logic rs_empty;
  logic rs_full;
  logic redirect_req;
  logic do_push;
  logic do_pop;
  logic bypass_take;

  // Status comes from registered state only, so rdy has no input-to-output path.
  assign rs_empty = (cnt_q == '0);
  assign rs_full  = (cnt_q == CNT_FULL);

  assign pc                        = pc_q;
  assign bju_rs_cnt                = cnt_q;
  assign bju_rs_empty              = rs_empty;
  assign bju_rs_full               = rs_full;
  assign idu_exu_rf_bju_pcjump_rdy = !rs_full;
  assign bju_rs_ovf                = ovf_q;
  assign bju_rs_unf                = unf_q;

  // Next-state: pc selection, push/pop arbitration, pointer and flag updates.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    jump_pend_d  = jump_pend_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    do_pop       = 1'b0;
    do_push      = 1'b0;
    bypass_take  = 1'b0;
    redirect_req = rob_idu_rf_pcjump_vld | jump_pend_q;

    if (rob_idu_rf_flush_vld) begin
      pc_d        = rob_idu_rf_flush_addr & ALIGN_MASK;
      jump_pend_d = 1'b0;
    end else if (y_stall_ctrl) begin
      // A commit that lands during a stall is remembered and served later.
      if (rob_idu_rf_pcjump_vld) jump_pend_d = 1'b1;
    end else if (redirect_req) begin
      if (!rs_empty) begin
        pc_d        = mem_q[rd_ptr_q];
        do_pop      = 1'b1;
        jump_pend_d = 1'b0;
      end else begin
`ifdef IDU_PC_GEN_BJU_BYPASS_EN
        if (exu_idu_rf_bju_pcjump_vld) begin
          pc_d        = exu_idu_rf_bju_pcjump_addr;
          bypass_take = 1'b1;
          jump_pend_d = 1'b0;
        end else begin
          jump_pend_d = 1'b1;
        end
`else
        unf_d       = 1'b1;
        jump_pend_d = 1'b0;
        pc_d        = pc_q + PC_INC;
`endif
      end
    end else begin
      pc_d = pc_q + PC_INC;
    end

    // A pop in the same cycle frees the slot a full station needs for a push.
    if (exu_idu_rf_bju_pcjump_vld && !rob_idu_rf_flush_vld && !bypass_take) begin
      if (!rs_full || do_pop) do_push = 1'b1;
      else                    ovf_d   = 1'b1;
    end

    if (rob_idu_rf_flush_vld) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    if (rst_clk) begin
      pc_q        <= PC_RST_VAL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      jump_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      jump_pend_q <= jump_pend_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Station storage: write the tail entry on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset; an entry is only read
    // once cnt says it was written, so reset logic on it would be wasted.
    if (!rst_clk && do_push) mem_q[wr_ptr_q] <= exu_idu_rf_bju_pcjump_addr;
  end

endmodule

// File: tb/tb_idu_pc_gen.sv
// Scoreboard bench for idu_pc_gen (default parameters).
// The driver applies one vector per cycle and queues the state expected after
// the next rising edge; a monitor samples just after that edge and compares.
module tb_idu_pc_gen;

  logic        clk;
  logic        rst_clk;
  logic        y_stall_ctrl;
  logic        bju_vld;
  logic [63:0] bju_addr;
  logic        bju_rdy;
  logic        rob_jump;
  logic        rob_flush;
  logic [63:0] flush_addr;
  logic [63:0] pc;
  logic [2:0]  cnt;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        unf;

  idu_pc_gen dut (
    .clk                        (clk),
    .rst_clk                    (rst_clk),
    .y_stall_ctrl               (y_stall_ctrl),
    .exu_idu_rf_bju_pcjump_vld  (bju_vld),
    .exu_idu_rf_bju_pcjump_addr (bju_addr),
    .idu_exu_rf_bju_pcjump_rdy  (bju_rdy),
    .rob_idu_rf_pcjump_vld      (rob_jump),
    .rob_idu_rf_flush_vld       (rob_flush),
    .rob_idu_rf_flush_addr      (flush_addr),
    .pc                         (pc),
    .bju_rs_cnt                 (cnt),
    .bju_rs_empty               (empty),
    .bju_rs_full                (full),
    .bju_rs_ovf                 (ovf),
    .bju_rs_unf                 (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          cpc;
    logic [63:0] pc;
    bit          ccnt;
    int          cnt;
    bit          cflg;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input bit cpc, input logic [63:0] p,
                              input bit ccnt, input int c,
                              input bit cflg, input bit o, input bit u);
    exp_t e;
    e.name = n; e.cpc = cpc; e.pc = p; e.ccnt = ccnt; e.cnt = c;
    e.cflg = cflg; e.ovf = o; e.unf = u;
    return e;
  endfunction

  // Apply one cycle of stimulus at the falling edge and queue its expectation.
  task automatic drive(input bit rst, input bit stall, input bit pv, input logic [63:0] pa,
                       input bit rj, input bit fl, input logic [63:0] fa, input exp_t e);
    @(negedge clk);
    rst_clk      = rst;
    y_stall_ctrl = stall;
    bju_vld      = pv;
    bju_addr     = pa;
    rob_jump     = rj;
    rob_flush    = fl;
    flush_addr   = fa;
    sb.push_back(e);
  endtask

  // Monitor: just after each rising edge, compare every queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.cpc) check({e.name, ".pc"}, pc, e.pc);
        if (e.ccnt) begin
          check({e.name, ".cnt"},   64'(cnt),   64'(e.cnt));
          check({e.name, ".empty"}, 64'(empty), 64'(e.cnt == 0));
          check({e.name, ".full"},  64'(full),  64'(e.cnt == 4));
          check({e.name, ".rdy"},   64'(bju_rdy), 64'(e.cnt != 4));
        end
        if (e.cflg) begin
          check({e.name, ".ovf"}, 64'(ovf), 64'(e.ovf));
          check({e.name, ".unf"}, 64'(unf), 64'(e.unf));
        end
      end
    end
  end

  localparam logic [63:0] R = 64'h8000_0000;

  initial begin
    rst_clk = 1'b1; y_stall_ctrl = 1'b0; bju_vld = 1'b0; bju_addr = '0;
    rob_jump = 1'b0; rob_flush = 1'b0; flush_addr = '0;

    // Reset held two cycles, then sequential fetch.
    drive(1, 0, 0, 0, 0, 0, 0, mk("rst1", 1, R, 1, 0, 1, 0, 0));
    drive(1, 0, 0, 0, 0, 0, 0, mk("rst2", 1, R, 1, 0, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("seq1", 1, R + 4, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("seq2", 1, R + 8, 1, 0, 0, 0, 0));

    // Fill the station, overflow, then pop two.
    drive(0, 0, 1, 64'h1000, 0, 0, 0, mk("push1", 1, R + 12, 1, 1, 0, 0, 0));
    drive(0, 0, 1, 64'h2000, 0, 0, 0, mk("push2", 1, R + 16, 1, 2, 0, 0, 0));
    drive(0, 0, 1, 64'h3000, 0, 0, 0, mk("push3", 1, R + 20, 1, 3, 0, 0, 0));
    drive(0, 0, 1, 64'h4000, 0, 0, 0, mk("push4", 1, R + 24, 1, 4, 1, 0, 0));
    drive(0, 0, 1, 64'h5000, 0, 0, 0, mk("push_ovf", 1, R + 28, 1, 4, 1, 1, 0));
    drive(0, 0, 0, 0, 1, 0, 0, mk("pop1", 1, 64'h1000, 1, 3, 0, 0, 0));
    drive(0, 0, 0, 0, 1, 0, 0, mk("pop2", 1, 64'h2000, 1, 2, 0, 0, 0));

    // Refill to full, then push and pop together.
    drive(0, 0, 1, 64'h5000, 0, 0, 0, mk("refill1", 1, 64'h2004, 1, 3, 0, 0, 0));
    drive(0, 0, 1, 64'h5800, 0, 0, 0, mk("refill2", 1, 64'h2008, 1, 4, 0, 0, 0));
    drive(0, 0, 1, 64'h6000, 1, 0, 0, mk("full_pushpop", 1, 64'h3000, 1, 4, 1, 1, 0));
    drive(0, 0, 0, 0, 1, 0, 0, mk("drain1", 1, 64'h4000, 1, 3, 0, 0, 0));
    drive(0, 0, 0, 0, 1, 0, 0, mk("drain2", 1, 64'h5000, 1, 2, 0, 0, 0));
    drive(0, 0, 0, 0, 1, 0, 0, mk("drain3", 1, 64'h5800, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 1, 0, 0, mk("drain_tail", 1, 64'h6000, 1, 0, 0, 0, 0));

    // Jump committed during a stall is held until the stall releases.
    drive(0, 0, 1, 64'hA000, 0, 0, 0, mk("pushA", 1, 64'h6004, 1, 1, 0, 0, 0));
    drive(0, 1, 0, 0, 1, 0, 0, mk("stall1", 1, 64'h6004, 1, 1, 0, 0, 0));
    drive(0, 1, 0, 0, 0, 0, 0, mk("stall2", 1, 64'h6004, 1, 1, 0, 0, 0));
    drive(0, 1, 0, 0, 0, 0, 0, mk("stall3", 1, 64'h6004, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("unstall", 1, 64'hA000, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("after_pend", 1, 64'hA004, 1, 0, 1, 1, 0));

    // Flush while stalled with a push and a jump: all discarded, pc aligned.
    drive(0, 0, 1, 64'hC000, 0, 0, 0, mk("pushC", 1, 64'hA008, 1, 1, 0, 0, 0));
    drive(0, 0, 1, 64'hD000, 0, 0, 0, mk("pushD", 1, 64'hA00C, 1, 2, 0, 0, 0));
    drive(0, 1, 1, 64'hE000, 1, 1, 64'h9003, mk("flush", 1, 64'h9000, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("post_flush", 1, 64'h9004, 1, 0, 1, 1, 0));

    // Redirect with an empty station and a same-cycle push.
`ifdef IDU_PC_GEN_BJU_BYPASS_EN
    drive(0, 0, 1, 64'hB000, 1, 0, 0, mk("empty_jump", 1, 64'hB000, 1, 0, 1, 1, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("empty_jump_next", 1, 64'hB004, 1, 0, 1, 1, 0));
`else
    drive(0, 0, 1, 64'hB000, 1, 0, 0, mk("empty_jump", 1, 64'h9008, 1, 1, 1, 1, 1));
    drive(0, 0, 0, 0, 0, 0, 0, mk("empty_jump_next", 1, 64'h900C, 1, 1, 1, 1, 1));
`endif

    // Mid-operation reset clears entries and sticky flags.
    drive(1, 0, 0, 0, 0, 0, 0, mk("rst_mid", 1, R, 1, 0, 1, 0, 0));

    // pc wraps from all-ones-aligned to zero.
    drive(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
          mk("flush_top", 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("wrap0", 1, 64'h0, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, mk("wrap4", 1, 64'h4, 1, 0, 1, 0, 0));

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
